meteor_field: RTL and testbench

- Produces the obstacle set consumed by the player ship block: per-slot x, y, size and alive arrays.
- Each slot is a meteorite that spawns at the top of the screen at a pseudo-random x and size, falls one step per frame, and retires when it passes the bottom edge.
- Counts dodged meteorites as the score.
- Freezes the field when the ship reports a collision on its die flag.

---
 rtl/meteor_field.sv | 130 +++++++++++++
 tb/tb_meteor_field.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/meteor_field.sv
`timescale 1ns/1ps
// meteor_field: falling meteorite obstacle field with spawn, fall, retire, scoring and freeze-on-collision.
// Optional define SPEED_RAMP_EN makes the fall step grow with the score (capped at 8 px/frame).
module meteor_field #(
  parameter int          obj_num      = 4,
  parameter int          SPAWN_PERIOD = 40,
  parameter int          FALL_STEP    = 2,
  parameter int          Y_LIMIT      = 479,
  parameter int          SIZE_MIN     = 8,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        Ball_die,
  output logic [9:0]  enemy_x      [obj_num],
  output logic [9:0]  enemy_y      [obj_num],
  output logic [9:0]  enemy_size   [obj_num],
  output logic        enermy_alive [obj_num],
  output logic [15:0] score,
  output logic        frozen
);

  localparam logic [15:0] RELOAD = 16'(SPAWN_PERIOD - 1);

  typedef enum logic {RUN, FROZEN} state_t;

  state_t      state, state_next;
  logic        run_en;
  logic [15:0] lfsr, lfsr_next;
  logic [15:0] spawn_cnt;
  logic [3:0]  step;
  logic [10:0] fall_next  [obj_num];
  logic        retire     [obj_num];
  logic        spawn_sel  [obj_num];
  logic        any_free;
  logic        spawn;
  logic [9:0]  spawn_x, spawn_size;
  logic [16:0] retire_cnt, score_sum;
  logic [15:0] score_next;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state <= RUN;
    else       state <= state_next;
  end

  // Freezing is terminal; only Reset brings the field back to RUN.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (Ball_die) state_next = FROZEN;
      FROZEN:  state_next = FROZEN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    run_en = (state == RUN) && !Ball_die;
    frozen = (state == FROZEN);
  end

`ifdef SPEED_RAMP_EN
  logic [16:0] ramp;
  always_comb begin
    ramp = 17'(FALL_STEP) + {4'b0, score[15:3]};
    step = (ramp > 17'd8) ? 4'd8 : ramp[3:0];
  end
`else
  assign step = 4'(FALL_STEP);
`endif

  // Fall in 11 bits so a meteor near the bottom cannot wrap back to the top.
  always_comb begin
    any_free   = 1'b0;
    retire_cnt = '0;
    for (int i = 0; i < obj_num; i++) begin
      spawn_sel[i] = 1'b0;
      fall_next[i] = {1'b0, enemy_y[i]} + {7'b0, step};
      retire[i]    = enermy_alive[i] && (fall_next[i] > 11'(Y_LIMIT));
      if (!enermy_alive[i] && !any_free) begin
        spawn_sel[i] = 1'b1;
        any_free     = 1'b1;
      end
      retire_cnt = retire_cnt + {16'b0, retire[i]};
    end
  end

  always_comb begin
    lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    spawn      = run_en && (spawn_cnt == 16'd0) && any_free;
    spawn_x    = {1'b0, lfsr[8:0]} + 10'd40;
    spawn_size = 10'(SIZE_MIN) + {6'b0, lfsr[12:9]};
    score_sum  = {1'b0, score} + retire_cnt;
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // Counter parks at zero while every slot is busy, so the spawn fires as soon as one frees up.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      lfsr      <= SEED;
      spawn_cnt <= RELOAD;
      score     <= '0;
      for (int i = 0; i < obj_num; i++) begin
        enemy_x[i]      <= '0;
        enemy_y[i]      <= '0;
        enemy_size[i]   <= '0;
        enermy_alive[i] <= 1'b0;
      end
    end else if (run_en) begin
      lfsr  <= lfsr_next;
      score <= score_next;
      if (spawn_cnt != 16'd0)
        spawn_cnt <= spawn_cnt - 16'd1;
      else if (any_free)
        spawn_cnt <= RELOAD;
      for (int i = 0; i < obj_num; i++) begin
        if (spawn && spawn_sel[i]) begin
          enermy_alive[i] <= 1'b1;
          enemy_y[i]      <= '0;
          enemy_x[i]      <= spawn_x;
          enemy_size[i]   <= spawn_size;
        end else if (retire[i]) begin
          enermy_alive[i] <= 1'b0;
        end else if (enermy_alive[i]) begin
          enemy_y[i] <= fall_next[i][9:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_meteor_field.sv
`timescale 1ns/1ps
// tb_meteor_field: directed checks of spawn timing, fall/retire, slot reuse, freeze and async reset.
module tb_meteor_field;

  logic        frame_clk;
  logic        Reset;
  logic        rstFast;
  logic        Ball_die;
  logic [9:0]  enemy_x [4];
  logic [9:0]  enemy_y [4];
  logic [9:0]  enemy_size [4];
  logic        enermy_alive [4];
  logic [15:0] score;
  logic        frozen;
  logic [9:0]  fastX [4];
  logic [9:0]  fastY [4];
  logic [9:0]  fastSize [4];
  logic        fastAlive [4];
  logic [15:0] fastScore;
  logic        fastFrozen;
  int          numChecks;
  int          numFails;

  meteor_field dut (
    .frame_clk(frame_clk), .Reset(Reset), .Ball_die(Ball_die),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_size(enemy_size),
    .enermy_alive(enermy_alive), .score(score), .frozen(frozen)
  );

  meteor_field #(.SPAWN_PERIOD(1)) dutFast (
    .frame_clk(frame_clk), .Reset(rstFast), .Ball_die(1'b0),
    .enemy_x(fastX), .enemy_y(fastY), .enemy_size(fastSize),
    .enermy_alive(fastAlive), .score(fastScore), .frozen(fastFrozen)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] lfsrAdvance(input int n);
    logic [15:0] s;
    s = 16'hACE1;
    for (int k = 0; k < n; k++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s;
  endfunction

  function automatic logic [9:0] expX(input int n);
    logic [15:0] s;
    s = lfsrAdvance(n);
    return {1'b0, s[8:0]} + 10'd40;
  endfunction

  function automatic logic [9:0] expSize(input int n);
    logic [15:0] s;
    s = lfsrAdvance(n);
    return 10'd8 + {6'b0, s[12:9]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic die, input int frames);
    Ball_die = die;
    repeat (frames) @(posedge frame_clk);
    #2;
  endtask

  task automatic checkAllReset(input string tag);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s_alive%0d", tag, i), 32'(enermy_alive[i]), 32'd0);
      checkOutput($sformatf("%s_x%0d", tag, i), 32'(enemy_x[i]), 32'd0);
      checkOutput($sformatf("%s_y%0d", tag, i), 32'(enemy_y[i]), 32'd0);
      checkOutput($sformatf("%s_size%0d", tag, i), 32'(enemy_size[i]), 32'd0);
    end
    checkOutput({tag, "_score"}, 32'(score), 32'd0);
    checkOutput({tag, "_frozen"}, 32'(frozen), 32'd0);
  endtask

  task automatic checkFrozenField(input string tag);
    checkOutput({tag, "_frozen"}, 32'(frozen), 32'd1);
    checkOutput({tag, "_y0"}, 32'(enemy_y[0]), 32'd38);
    checkOutput({tag, "_y1"}, 32'(enemy_y[1]), 32'd440);
    checkOutput({tag, "_y2"}, 32'(enemy_y[2]), 32'd360);
    checkOutput({tag, "_y3"}, 32'(enemy_y[3]), 32'd280);
    checkOutput({tag, "_x0"}, 32'(enemy_x[0]), 32'(expX(280)));
    checkOutput({tag, "_score"}, 32'(score), 32'd1);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("%s_alive%0d", tag, i), 32'(enermy_alive[i]), 32'd1);
  endtask

  initial begin
    numChecks = 0;
    numFails  = 0;
    Reset     = 1'b1;
    rstFast   = 1'b1;
    Ball_die  = 1'b0;
    #12;
    checkAllReset("reset");

    Reset = 1'b0;
    applyStimulus(1'b0, 39);
    checkOutput("e39_alive0", 32'(enermy_alive[0]), 32'd0);
    applyStimulus(1'b0, 1);
    checkOutput("e40_alive0", 32'(enermy_alive[0]), 32'd1);
    checkOutput("e40_y0", 32'(enemy_y[0]), 32'd0);
    checkOutput("e40_x0", 32'(enemy_x[0]), 32'(expX(39)));
    checkOutput("e40_size0", 32'(enemy_size[0]), 32'(expSize(39)));
    checkOutput("e40_x0_range", 32'(enemy_x[0] >= 10'd40 && enemy_x[0] <= 10'd551), 32'd1);
    checkOutput("e40_size0_range", 32'(enemy_size[0] >= 10'd8 && enemy_size[0] <= 10'd23), 32'd1);
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("e40_alive%0d", i), 32'(enermy_alive[i]), 32'd0);

    applyStimulus(1'b0, 39);
    checkOutput("e79_alive1", 32'(enermy_alive[1]), 32'd0);
    checkOutput("e79_y0", 32'(enemy_y[0]), 32'd78);
    applyStimulus(1'b0, 1);
    checkOutput("e80_alive1", 32'(enermy_alive[1]), 32'd1);
    checkOutput("e80_y1", 32'(enemy_y[1]), 32'd0);
    checkOutput("e80_x1", 32'(enemy_x[1]), 32'(expX(79)));
    checkOutput("e80_y0", 32'(enemy_y[0]), 32'd80);

    applyStimulus(1'b0, 199);
    checkOutput("e279_y0", 32'(enemy_y[0]), 32'd478);
    checkOutput("e279_y1", 32'(enemy_y[1]), 32'd398);
    checkOutput("e279_score", 32'(score), 32'd0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("e279_alive%0d", i), 32'(enermy_alive[i]), 32'd1);

    applyStimulus(1'b0, 1);
    checkOutput("e280_alive0", 32'(enermy_alive[0]), 32'd0);
    checkOutput("e280_y0", 32'(enemy_y[0]), 32'd478);
    checkOutput("e280_x0", 32'(enemy_x[0]), 32'(expX(39)));
    checkOutput("e280_score", 32'(score), 32'd1);

    applyStimulus(1'b0, 1);
    checkOutput("e281_alive0", 32'(enermy_alive[0]), 32'd1);
    checkOutput("e281_y0", 32'(enemy_y[0]), 32'd0);
    checkOutput("e281_x0", 32'(enemy_x[0]), 32'(expX(280)));
    checkOutput("e281_size0", 32'(enemy_size[0]), 32'(expSize(280)));

    applyStimulus(1'b0, 19);
    checkOutput("e300_frozen", 32'(frozen), 32'd0);
    checkOutput("e300_y0", 32'(enemy_y[0]), 32'd38);

    applyStimulus(1'b1, 1);
    checkFrozenField("die_edge");
    applyStimulus(1'b0, 50);
    checkFrozenField("frozen50");

    Reset = 1'b1;
    #1;
    checkAllReset("reset_frozen");
    Reset = 1'b0;

    applyStimulus(1'b0, 50);
    checkOutput("midfall_y0", 32'(enemy_y[0]), 32'd20);
    Reset = 1'b1;
    #1;
    checkAllReset("reset_async");
    Reset = 1'b0;
    applyStimulus(1'b0, 39);
    checkOutput("rerun_e39_alive0", 32'(enermy_alive[0]), 32'd0);
    applyStimulus(1'b0, 1);
    checkOutput("rerun_e40_alive0", 32'(enermy_alive[0]), 32'd1);
    checkOutput("rerun_e40_x0", 32'(enemy_x[0]), 32'(expX(39)));
    checkOutput("rerun_e40_size0", 32'(enemy_size[0]), 32'(expSize(39)));

    rstFast = 1'b0;
    applyStimulus(1'b0, 1);
    checkOutput("fast_e1_alive0", 32'(fastAlive[0]), 32'd1);
    checkOutput("fast_e1_x0", 32'(fastX[0]), 32'd265);
    checkOutput("fast_e1_size0", 32'(fastSize[0]), 32'd14);
    checkOutput("fast_e1_alive1", 32'(fastAlive[1]), 32'd0);
    applyStimulus(1'b0, 3);
    checkOutput("fast_e4_alive3", 32'(fastAlive[3]), 32'd1);
    checkOutput("fast_e4_y0", 32'(fastY[0]), 32'd6);
    applyStimulus(1'b0, 236);
    checkOutput("fast_e240_y0", 32'(fastY[0]), 32'd478);
    checkOutput("fast_e240_y3", 32'(fastY[3]), 32'd472);
    checkOutput("fast_e240_score", 32'(fastScore), 32'd0);
    applyStimulus(1'b0, 1);
    checkOutput("fast_e241_alive0", 32'(fastAlive[0]), 32'd0);
    checkOutput("fast_e241_y0", 32'(fastY[0]), 32'd478);
    checkOutput("fast_e241_alive1", 32'(fastAlive[1]), 32'd1);
    checkOutput("fast_e241_score", 32'(fastScore), 32'd1);
    applyStimulus(1'b0, 1);
    checkOutput("fast_e242_alive0", 32'(fastAlive[0]), 32'd1);
    checkOutput("fast_e242_y0", 32'(fastY[0]), 32'd0);
    checkOutput("fast_e242_x0", 32'(fastX[0]), 32'(expX(241)));
    checkOutput("fast_e242_alive1", 32'(fastAlive[1]), 32'd0);
    checkOutput("fast_e242_y1", 32'(fastY[1]), 32'd478);
    checkOutput("fast_e242_score", 32'(fastScore), 32'd2);
    checkOutput("fast_frozen", 32'(fastFrozen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
